// File: rtl/up_ofdmbbp_queues.sv
// Register-mapped queue bank between up_axi and the BBP core: NUM_CMDQ FWFT command
// queues, one result queue, sticky overflow/underflow flags, flush, soft core reset, irq.
module up_ofdmbbp_queues #(
    parameter int          NUM_CMDQ   = 2,
    parameter int          CMD_WIDTH  = 32,
    parameter int          CMD_DEPTH  = 128,
    parameter int          DATA_WIDTH = 24,
    parameter int          DATA_DEPTH = 1024,
    parameter logic [31:0] VERSION    = 32'h00020000
) (
    input  logic                          up_clk,
    input  logic                          up_rstn,
    input  logic                          up_wreq,
    input  logic [13:0]                   up_waddr,
    input  logic [31:0]                   up_wdata,
    output logic                          up_wack,
    input  logic                          up_rreq,
    input  logic [13:0]                   up_raddr,
    output logic [31:0]                   up_rdata,
    output logic                          up_rack,
    output logic [NUM_CMDQ-1:0]           cmd_valid,
    input  logic [NUM_CMDQ-1:0]           cmd_ready,
    output logic [NUM_CMDQ*CMD_WIDTH-1:0] cmd_data,
    input  logic                          dout_valid,
    output logic                          dout_ready,
    input  logic [DATA_WIDTH-1:0]         dout_data,
    output logic                          core_rst,
    output logic                          irq
);
    localparam int           CAW       = $clog2(CMD_DEPTH);
    localparam int           DAW       = $clog2(DATA_DEPTH);
    localparam logic [CAW:0] CMD_FULL  = (CAW+1)'(CMD_DEPTH);
    localparam logic [DAW:0] DATA_FULL = (DAW+1)'(DATA_DEPTH);

    logic [CMD_WIDTH-1:0]  cmd_mem  [NUM_CMDQ][CMD_DEPTH];
    logic [CAW-1:0]        cmd_wptr [NUM_CMDQ];
    logic [CAW-1:0]        cmd_rptr [NUM_CMDQ];
    logic [CAW:0]          cmd_cnt  [NUM_CMDQ];
    logic [DATA_WIDTH-1:0] res_mem  [DATA_DEPTH];
    logic [DAW-1:0]        res_wptr, res_rptr;
    logic [DAW:0]          res_cnt;

    logic [31:0]         scratch;
    logic [1:0]          mask, flags, flag_set, flag_clr;
    logic                flush;
    logic [NUM_CMDQ-1:0] cmd_push, cmd_pop, cmd_ovf;
    logic                res_rd, res_pop, res_udf, res_push;
    logic [31:0]         rd_val;

    // A pop frees a slot in the same cycle, so a full queue still accepts a push then.
    assign res_rd     = up_rreq && (up_raddr == 14'h200);
    assign res_pop    = res_rd && (res_cnt != '0) && !flush;
    assign res_udf    = res_rd && (res_cnt == '0) && !flush;
    assign dout_ready = (res_cnt != DATA_FULL);
    assign res_push   = dout_valid && (dout_ready || res_pop) && !flush;

    always_comb begin
        cmd_push = '0;
        cmd_ovf  = '0;
        cmd_pop  = '0;
        for (int q = 0; q < NUM_CMDQ; q++) begin
            cmd_pop[q] = cmd_valid[q] && cmd_ready[q] && !flush;
            if (up_wreq && (up_waddr == 14'h100 + 14'(q)) && !flush) begin
                if ((cmd_cnt[q] != CMD_FULL) || cmd_pop[q]) cmd_push[q] = 1'b1;
                else                                        cmd_ovf[q]  = 1'b1;
            end
        end
    end

    assign flag_set = {res_udf, |cmd_ovf};
    assign flag_clr = (up_wreq && (up_waddr == 14'h009)) ? up_wdata[1:0] : 2'b00;

    for (genvar g = 0; g < NUM_CMDQ; g++) begin : g_head
        assign cmd_valid[g] = (cmd_cnt[g] != '0);
        assign cmd_data[g*CMD_WIDTH +: CMD_WIDTH] = cmd_valid[g] ? cmd_mem[g][cmd_rptr[g]] : '0;
    end

    always_ff @(posedge up_clk or negedge up_rstn) begin
        if (!up_rstn) begin
            for (int q = 0; q < NUM_CMDQ; q++) begin
                cmd_wptr[q] <= '0;
                cmd_rptr[q] <= '0;
                cmd_cnt[q]  <= '0;
            end
            res_wptr <= '0;
            res_rptr <= '0;
            res_cnt  <= '0;
        end else if (flush) begin
            for (int q = 0; q < NUM_CMDQ; q++) begin
                cmd_wptr[q] <= '0;
                cmd_rptr[q] <= '0;
                cmd_cnt[q]  <= '0;
            end
            res_wptr <= '0;
            res_rptr <= '0;
            res_cnt  <= '0;
        end else begin
            for (int q = 0; q < NUM_CMDQ; q++) begin
                if (cmd_push[q]) cmd_wptr[q] <= cmd_wptr[q] + CAW'(1);
                if (cmd_pop[q])  cmd_rptr[q] <= cmd_rptr[q] + CAW'(1);
                cmd_cnt[q] <= cmd_cnt[q] + (CAW+1)'(cmd_push[q]) - (CAW+1)'(cmd_pop[q]);
            end
            if (res_push) res_wptr <= res_wptr + DAW'(1);
            if (res_pop)  res_rptr <= res_rptr + DAW'(1);
            res_cnt <= res_cnt + (DAW+1)'(res_push) - (DAW+1)'(res_pop);
        end
    end

    always_ff @(posedge up_clk) begin
        for (int q = 0; q < NUM_CMDQ; q++) begin
            if (cmd_push[q]) cmd_mem[q][cmd_wptr[q]] <= up_wdata[CMD_WIDTH-1:0];
        end
        if (res_push) res_mem[res_wptr] <= dout_data;
    end

    // Flag set wins over a write-1-to-clear landing in the same cycle.
    always_ff @(posedge up_clk or negedge up_rstn) begin
        if (!up_rstn) begin
            up_wack  <= 1'b0;
            scratch  <= '0;
            core_rst <= 1'b1;
            mask     <= '0;
            flags    <= '0;
            flush    <= 1'b0;
            irq      <= 1'b0;
        end else begin
            up_wack <= up_wreq;
            flush   <= 1'b0;
            flags   <= (flags & ~flag_clr) | flag_set;
            irq     <= |(flags & mask);
            if (up_wreq) begin
                case (up_waddr)
                    14'h002: scratch <= up_wdata;
                    14'h004: begin
                        core_rst <= up_wdata[0];
                        flush    <= up_wdata[1];
                    end
                    14'h008: mask <= up_wdata[1:0];
                    default: ;
                endcase
            end
        end
    end

    always_comb begin
        rd_val = '0;
        case (up_raddr)
            14'h000: rd_val = VERSION;
            14'h002: rd_val = scratch;
            14'h004: rd_val = {31'd0, core_rst};
            14'h008: rd_val = {30'd0, mask};
            14'h009: rd_val = {30'd0, flags};
            14'h200: rd_val = res_pop ? 32'(res_mem[res_rptr]) : 32'd0;
            14'h201: rd_val = 32'(res_cnt);
            default: begin
                for (int q = 0; q < NUM_CMDQ; q++) begin
                    if (up_raddr == 14'h110 + 14'(q)) rd_val = 32'(cmd_cnt[q]);
                end
            end
        endcase
    end

    always_ff @(posedge up_clk or negedge up_rstn) begin
        if (!up_rstn) begin
            up_rack  <= 1'b0;
            up_rdata <= '0;
        end else begin
            up_rack  <= up_rreq;
            up_rdata <= up_rreq ? rd_val : 32'd0;
        end
    end
endmodule

// File: doc/up_ofdmbbp_queues.md
# up_ofdmbbp_queues

Parametrised register-mapped queue bank for the OFDM baseband processor, in the `up_axi` microprocessor-bus clock domain. It replaces the fixed single command FIFO and single data FIFO with `NUM_CMDQ` command queues and one result queue, all of configurable width and depth. It adds behaviour the fixed design lacks: overflow and underflow detection with sticky flags, core backpressure on a full result queue, flush, soft core reset, and an interrupt. It sits between `up_axi` and a BBP core running on the same clock; clock-domain crossing is outside this block.

## Interface
Parameters:
- `NUM_CMDQ`, 2: number of command queues, 1..8.
- `CMD_WIDTH`, 32: command word width, 1..32.
- `CMD_DEPTH`, 128: entries per command queue, power of two, ≥2.
- `DATA_WIDTH`, 24: result word width, 1..32.
- `DATA_DEPTH`, 1024: result queue entries, power of two, ≥2.
- `VERSION`, 32'h00020000: value returned at 0x000.

Ports (one clock; reset is asynchronous and active-low):
- `up_clk` in 1: bus and core clock.
- `up_rstn` in 1: asynchronous active-low reset.
- `up_wreq` in 1: write request, one-cycle pulse.
- `up_waddr` in 14: write word address.
- `up_wdata` in 32: write data.
- `up_wack` out 1: write acknowledge.
- `up_rreq` in 1: read request, one-cycle pulse.
- `up_raddr` in 14: read word address.
- `up_rdata` out 32: read data.
- `up_rack` out 1: read acknowledge.
- `cmd_valid` out NUM_CMDQ: per-queue head valid.
- `cmd_ready` in NUM_CMDQ: per-queue pop by core.
- `cmd_data` out NUM_CMDQ*CMD_WIDTH: head words; queue q occupies bits [q*CMD_WIDTH +: CMD_WIDTH].
- `dout_valid` in 1: core result strobe.
- `dout_ready` out 1: result queue not full.
- `dout_data` in DATA_WIDTH: core result word.
- `core_rst` out 1: soft reset to the core, active-high.
- `irq` out 1: level interrupt.

## Operation
Register map (word addresses):
- 0x000: `VERSION`, read-only.
- 0x002: scratch, read/write.
- 0x004: control. Bit 0 is `core_rst`, reset value 1. Writing bit 1 as 1 triggers a flush pulse; bit 1 always reads 0.
- 0x008: irq mask, bits [1:0]; reset value 0.
- 0x009: sticky flags. Bit 0 is overflow (push to a full command queue). Bit 1 is underflow (pop of an empty result queue). Writing 1 to a bit clears it.
- 0x100+q: push `up_wdata[CMD_WIDTH-1:0]` into command queue q. Reads return 0.
- 0x110+q: queue q occupancy in bits [log2(CMD_DEPTH):0], read-only.
- 0x200: pop the result queue. The head word is zero-extended into `up_rdata`.
- 0x201: result queue occupancy, read-only.
- Unmapped addresses and q ≥ NUM_CMDQ: reads return 0 and writes are ignored. Both are still acknowledged.

Queue behaviour:
- Command queues are first-word-fall-through. `cmd_valid[q]` = queue q not empty, and `cmd_data` shows the head word. The queue pops on a clock edge when `cmd_valid[q] & cmd_ready[q]`.
- A push to a full command queue is discarded, the queue is unchanged, and overflow is set.
- The result queue pushes on `dout_valid & dout_ready`. `dout_ready` = not full, combinational from the count. While full, `dout_valid` is ignored and does not set overflow; backpressure is the core's responsibility.
- A read of 0x200 while the result queue is empty returns 0, leaves the queue unchanged, and sets underflow.
- Simultaneous push and pop on the same queue (non-empty, non-full): both take effect, count unchanged. On a full queue the pop frees the slot first, so the push is accepted. On an empty queue the push is accepted and the pop is treated as an empty pop.
- Flush empties every queue (pointers and counts to 0) on the edge after the write. Pushes and pops in that cycle are discarded. Flags are not cleared.
- `irq` = |(flags & mask), registered.
- Pointers wrap modulo depth. Counts are log2(depth)+1 bits and reach `DEPTH` exactly.

## Timing
- Reset values: `up_wack`=0, `up_rack`=0, `up_rdata`=0, `core_rst`=1, `irq`=0, `cmd_valid`=0, `cmd_data`=0, `dout_ready`=1. Scratch, mask and flags are 0; all queues are empty.
- `up_wack` asserts exactly one cycle after `up_wreq`. Register and queue state update on that same edge.
- `up_rack` asserts one cycle after `up_rreq`, and `up_rdata` is valid in that cycle. A pop from 0x200 takes effect on the same edge that registers `up_rdata`.
- Command push to `cmd_valid` rising: 1 cycle. Result push to the 0x201 count update: 1 cycle.
- `irq` follows a flag set by 1 cycle.
- Asserting `up_rstn` mid-operation clears all state asynchronously. No partial transaction is acknowledged.

## Test plan
- Reset release: read 0x000 → `VERSION`; read 0x004 → 1; `core_rst`=1 and `cmd_valid`=0; write 0x004=0 → `core_rst`=0 one cycle later.
- Command queue q=1, `CMD_DEPTH`=4: push 5 words 0xA0..0xA4 with `cmd_ready` held low → 0x111 reads 4 and 0x009 reads 1. Then raise `cmd_ready` → `cmd_data` shows 0xA0..0xA3 in order, and `cmd_valid[1]` drops after 4 cycles.
- Result queue, `DATA_DEPTH`=4: drive `dout_valid` for 6 cycles → `dout_ready` low after the 4th accept. Four reads of 0x200 return words 0..3, and a fifth read returns 0 and sets 0x009 bit 1.
- Simultaneous push/pop: full result queue with a 0x200 read and `dout_valid` in the same cycle → count stays 4 and the word order is preserved.
- Interrupt: mask=0x2, then underflow → `irq`=1 one cycle later; write 0x009=2 → `irq`=0.
- Flush with all queues non-empty: write 0x004=3 → all counts 0 and `cmd_valid`=0; flags are retained.
